// File: rtl/staggered_add_seq.sv
// staggered_add_seq: WIDTH-bit adder evaluated one nibble per clock, LSB first,
// through a single shared 4-bit carry-lookahead slice (cla4bit).
// Optional signed-overflow output enabled by defining STAG_ADD_OVF_EN.

module cla4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  // Generate/propagate lookahead carries for one nibble
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    co   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    s    = p ^ c;
  end

endmodule

module staggered_add_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef STAG_ADD_OVF_EN
  output logic             ovf,
`endif
  output logic             co
);

  localparam int unsigned NSL = WIDTH / 4;
  localparam int unsigned IW  = (NSL > 1) ? $clog2(NSL) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic             cr;
  logic [IW-1:0]    idx;
  logic [3:0]       sl_a;
  logic [3:0]       sl_b;
  logic [3:0]       sl_s;
  logic             sl_co;
  logic             last;
  logic             accept;

  // Select the operand nibbles for the current slice
  always_comb begin
    sl_a   = ra[{idx, 2'b00} +: 4];
    sl_b   = rb[{idx, 2'b00} +: 4];
    last   = (idx == IW'(NSL - 1));
    accept = in_valid && in_ready;
  end

  cla4bit u_cla (
    .a  (sl_a),
    .b  (sl_b),
    .ci (cr),
    .s  (sl_s),
    .co (sl_co)
  );

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_RUN;
      S_RUN:   if (last) state_nxt = S_DONE;
      S_DONE:  if (out_valid && out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register with handshake flags decoded from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt == S_IDLE);
      out_valid <= (state_nxt == S_DONE);
    end
  end

  // Operand capture and per-slice accumulation of sum and carry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ra  <= '0;
      rb  <= '0;
      cr  <= 1'b0;
      idx <= '0;
      sum <= '0;
      co  <= 1'b0;
`ifdef STAG_ADD_OVF_EN
      ovf <= 1'b0;
`endif
    end else begin
      if (state == S_IDLE && accept) begin
        ra  <= a;
        rb  <= b;
        cr  <= ci;
        idx <= '0;
      end else if (state == S_RUN) begin
        sum[{idx, 2'b00} +: 4] <= sl_s;
        cr                     <= sl_co;
        idx                    <= idx + IW'(1);
        if (last) begin
          co  <= sl_co;
`ifdef STAG_ADD_OVF_EN
          ovf <= (ra[WIDTH-1] == rb[WIDTH-1]) && (sl_s[3] != ra[WIDTH-1]);
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_staggered_add_seq.sv
// Testbench for staggered_add_seq: directed corner cases plus randomized
// back-to-back operations checked against a plain-arithmetic reference.
// Define STAG_ADD_OVF_EN to also exercise the overflow output.

module tb_staggered_add_seq;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ci;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         co;
`ifdef STAG_ADD_OVF_EN
  logic         ovf;
`endif

  int n_chk = 0;
  int n_err = 0;

  staggered_add_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ci        (ci),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
`ifdef STAG_ADD_OVF_EN
    .ovf       (ovf),
`endif
    .co        (co)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: {co,sum} = a + b + ci as one wide addition
  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c);
    return {1'b0, x} + {1'b0, y} + (W+1)'(c);
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic c);
    logic [W:0] r;
    r = ref_add(x, y, c);
    return (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 30) begin
      tick();
      n++;
    end
    if (!in_ready) check("wait_in_ready_timeout", 64'(in_ready), 64'd1);
  endtask

  // One operation; optional backpressure in DONE before the output handshake
  task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic c, input logic [W-1:0] es, input logic ec,
                        input logic eo, input bit hold);
    int lat;
    logic [W-1:0] hs;
    logic         hc;
    wait_ready();
    a = x; b = y; ci = c; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; a = $urandom; b = $urandom; ci = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 30) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'd8);
    check({tag, "_sum"}, 64'(sum), 64'(es));
    check({tag, "_co"}, 64'(co), 64'(ec));
`ifdef STAG_ADD_OVF_EN
    check({tag, "_ovf"}, 64'(ovf), 64'(eo));
`else
    if (eo !== eo) check({tag, "_ovf_x"}, 64'(eo), 64'(0));
`endif
    if (hold) begin
      hs = sum; hc = co;
      for (int i = 0; i < 5; i++) begin
        in_valid = 1'($urandom); a = $urandom; b = $urandom; ci = 1'($urandom);
        tick();
        check({tag, "_hold_sum"}, 64'(sum), 64'(es));
        check({tag, "_hold_co"}, 64'(co), 64'(hc));
        check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
      end
      if (hs !== es) check({tag, "_hold_start"}, 64'(hs), 64'(es));
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_release_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_release_in_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [W:0]   r;
    logic [W+1:0] exp_q[$];
    logic [W+1:0] e;
    int cyc, last_acc, n_acc, n_done;
    logic [W-1:0] x, y;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; ci = 1'b0;
    #12;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_co", 64'(co), 64'd0);
    tick();
    rst = 1'b0;

    run_op("ripple", 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0);
    run_op("mixed", 32'h12345678, 32'h9ABCDEF0, 1'b1, 32'hACF13569, 1'b0, 1'b0, 1'b0);
    r = ref_add(32'hDEADBEEF, 32'h01234567, 1'b1);
    run_op("backpressure", 32'hDEADBEEF, 32'h01234567, 1'b1, r[W-1:0], r[W],
           ref_ovf(32'hDEADBEEF, 32'h01234567, 1'b1), 1'b1);

    // Reset mid-operation after three RUN cycles
    wait_ready();
    a = 32'h12345678; b = 32'h11111111; ci = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    #1;
    check("midrst_sum", 64'(sum), 64'd0);
    check("midrst_co", 64'(co), 64'd0);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd0);
    tick();
    rst = 1'b0;
    run_op("after_rst", 32'h0000000F, 32'h00000001, 1'b0, 32'h00000010, 1'b0, 1'b0, 1'b0);

`ifdef STAG_ADD_OVF_EN
    run_op("ovf_pos", 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
    run_op("ovf_neg", 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b0);
    run_op("ovf_none", 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0);
`endif

    // Back-to-back random operations with in_valid and out_ready held high
    wait_ready();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a = $urandom; b = $urandom; ci = 1'($urandom);
    cyc = 0; last_acc = 0; n_acc = 0; n_done = 0;
    while (n_done < 1000 && cyc < 11000) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("b2b_unexpected_result", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("b2b_sum", 64'(sum), 64'(e[W-1:0]));
          check("b2b_co", 64'(co), 64'(e[W]));
`ifdef STAG_ADD_OVF_EN
          check("b2b_ovf", 64'(ovf), 64'(e[W+1]));
`endif
        end
        n_done++;
      end
      if (in_ready && in_valid) begin
        x = a; y = b;
        r = ref_add(x, y, ci);
        exp_q.push_back({ref_ovf(x, y, ci), r});
        if (n_acc > 0) check("b2b_spacing", 64'(cyc - last_acc), 64'd10);
        last_acc = cyc;
        n_acc++;
      end
      tick();
      cyc++;
      a = $urandom; b = $urandom; ci = 1'($urandom);
      if (n_acc >= 1000) in_valid = 1'b0;
    end
    check("b2b_results", 64'(n_done), 64'd1000);
    out_ready = 1'b0;
    in_valid  = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
